// File: rtl/inv_cipher_ctrl.sv
// Control sequencer for the AES-128 inverse cipher: forward key expansion to the last round,
// then one datapath operation per cycle while the key schedule steps backward to round 0.
module inv_cipher_ctrl #(
    parameter int NR        = 10,
    parameter int SBOX_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    output logic       done,
    output logic [3:0] round,
    output logic       keyFwd,
    output logic       keyInv,
    output logic [3:0] operation
);

    localparam int CW = (SBOX_WAIT < 2) ? 1 : $clog2(SBOX_WAIT + 1);
    localparam logic [3:0]    RMAX = 4'(NR);
    localparam logic [CW-1:0] SW   = CW'(SBOX_WAIT);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ARK  = 4'd2;
    localparam logic [3:0] OP_ISR  = 4'd3;
    localparam logic [3:0] OP_ISB  = 4'd4;
    localparam logic [3:0] OP_IMC  = 4'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_KEYEXP, S_ARK0, S_ISR, S_ISB, S_ARK, S_IMC, S_DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    round_n, op_n;
    logic          done_n, fwd_n, inv_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            round     <= '0;
            done      <= 1'b0;
            keyFwd    <= 1'b0;
            keyInv    <= 1'b0;
            operation <= OP_NOP;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            round     <= round_n;
            done      <= done_n;
            keyFwd    <= fwd_n;
            keyInv    <= inv_n;
            operation <= op_n;
        end
    end

    // Outputs are computed for the state being entered so they register alongside it.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        round_n = round;
        op_n    = OP_NOP;
        done_n  = 1'b0;
        fwd_n   = 1'b0;
        inv_n   = 1'b0;

        case (state)
            S_IDLE: ;
            S_LOAD: begin
                state_n = S_KEYEXP;
                fwd_n   = 1'b1;
                round_n = 4'd1;
            end
            S_KEYEXP: begin
                if (round >= RMAX) begin
                    state_n = S_ARK0;
                    op_n    = OP_ARK;
                end else begin
                    fwd_n   = 1'b1;
                    round_n = round + 4'd1;
                end
            end
            S_ARK0, S_IMC: begin
                state_n = S_ISR;
                op_n    = OP_ISR;
                inv_n   = 1'b1;
                round_n = round - 4'd1;
            end
            S_ISR: begin
                state_n = S_ISB;
                op_n    = OP_ISB;
                cnt_n   = CW'(1);
            end
            S_ISB: begin
                if (cnt >= SW) begin
                    state_n = S_ARK;
                    op_n    = OP_ARK;
                end else begin
                    op_n  = OP_ISB;
                    cnt_n = cnt + CW'(1);
                end
            end
            S_ARK: begin
                // The final round skips InvMixColumns.
                if (round == 4'd0) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    state_n = S_IMC;
                    op_n    = OP_IMC;
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                round_n = 4'd0;
            end
            default: begin
                state_n = S_IDLE;
                round_n = 4'd0;
            end
        endcase

        // A load request from any state restarts from a fresh reload.
        if (load) begin
            state_n = S_LOAD;
            op_n    = OP_LOAD;
            round_n = 4'd0;
            cnt_n   = '0;
            done_n  = 1'b0;
            fwd_n   = 1'b0;
            inv_n   = 1'b0;
        end
    end

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Bench for inv_cipher_ctrl: SBOX_WAIT=1 and SBOX_WAIT=2 instances share stimulus and are
// checked every cycle against a sequence-level model, plus table vectors and corner-case sequences.
module tb_inv_cipher_ctrl;

    logic       clk = 1'b0;
    logic       reset, load;
    logic       done1, fwd1, inv1, done2, fwd2, inv2;
    logic [3:0] round1, op1, round2, op2;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    inv_cipher_ctrl #(.NR(10), .SBOX_WAIT(1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .done(done1), .round(round1),
        .keyFwd(fwd1), .keyInv(inv1), .operation(op1)
    );

    inv_cipher_ctrl #(.NR(10), .SBOX_WAIT(2)) dut2 (
        .clk(clk), .reset(reset), .load(load), .done(done2), .round(round2),
        .keyFwd(fwd2), .keyInv(inv2), .operation(op2)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rnd;
        logic       fwd;
        logic       inv;
    } step_t;

    // Expected post-load trajectory of each instance, one entry per cycle until done.
    step_t seq [2][80];
    int    seq_len [2];
    int    mode [2];
    int    idx [2];

    task automatic push(input int k, inout int n, input int op, input int r, input bit f, input bit i);
        seq[k][n] = '{4'(op), 4'(r), f, i};
        n = n + 1;
    endtask

    task automatic build(input int k, input int sw);
        int n = 0;
        for (int r = 1; r <= 10; r++) push(k, n, 0, r, 1'b1, 1'b0);
        push(k, n, 2, 10, 1'b0, 1'b0);
        for (int r = 9; r >= 0; r--) begin
            push(k, n, 3, r, 1'b0, 1'b1);
            for (int s = 0; s < sw; s++) push(k, n, 4, r, 1'b0, 1'b0);
            push(k, n, 2, r, 1'b0, 1'b0);
            if (r > 0) push(k, n, 5, r, 1'b0, 1'b0);
        end
        seq_len[k] = n;
    endtask

    // mode: 0 idle, 1 loading, 2 running (idx into seq), 3 done
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) mode[k] <= 0;
            else if (load) mode[k] <= 1;
            else if (mode[k] == 1) begin
                mode[k] <= 2;
                idx[k]  <= 0;
            end else if (mode[k] == 2) begin
                if (idx[k] + 1 == seq_len[k]) mode[k] <= 3;
                else idx[k] <= idx[k] + 1;
            end
        end
    end

    function automatic logic [10:0] expect_out(input int k);
        step_t s;
        case (mode[k])
            1: return {1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
            2: begin
                s = seq[k][idx[k]];
                return {1'b0, s.op, s.rnd, s.fwd, s.inv};
            end
            3: return {1'b1, 4'd0, 4'd0, 1'b0, 1'b0};
            default: return 11'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sw1_outputs", 32'({done1, op1, round1, fwd1, inv1}), 32'(expect_out(0)));
            chk("sw2_outputs", 32'({done2, op2, round2, fwd2, inv2}), 32'(expect_out(1)));
            chk("sw1_fwd_inv_excl", 32'(fwd1 & inv1), 32'd0);
            chk("sw2_fwd_inv_excl", 32'(fwd2 & inv2), 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       rst;
        logic       ld;
        logic       dn;
        logic [3:0] op;
        logic [3:0] rnd;
        logic       f;
        logic       i;
    } vec_t;

    vec_t tbl [8];
    int   lat1, lat2, bad;
    bit   found;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0};
        build(0, 1);
        build(1, 2);

        // Reset with load held, then load for 3 cycles and the start of key expansion.
        for (int i = 0; i < 8; i++) begin
            reset = tbl[i].rst;
            load  = tbl[i].ld;
            cyc();
            chk($sformatf("vector_%0d", i), 32'({done1, op1, round1, fwd1, inv1}),
                32'({tbl[i].dn, tbl[i].op, tbl[i].rnd, tbl[i].f, tbl[i].i}));
            chk_en = 1'b1;
        end

        // Cycles from the first keyFwd cycle (table row 5, offset 0) to done.
        lat1 = -1;
        lat2 = -1;
        for (int c = 3; c <= 130; c++) begin
            cyc();
            if (done1 && lat1 < 0) lat1 = c;
            if (done2 && lat2 < 0) lat2 = c;
        end
        chk("latency_sw1", 32'(lat1), 32'd50);
        chk("latency_sw2", 32'(lat2), 32'd60);
        chk("done_round", 32'(round1), 32'd0);

        bad = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (!done1 || op1 != 4'd0) bad++;
        end
        chk("done_hold_bad_cycles", 32'(bad), 32'd0);

        load = 1'b1;
        cyc();
        chk("reload_done", 32'(done1), 32'd0);
        chk("reload_op", 32'(op1), 32'd1);
        load = 1'b0;
        cyc();
        chk("restart_fwd", 32'(fwd1), 32'd1);

        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (op1 == 4'd4 && round1 == 4'd5) found = 1'b1;
            else cyc();
        end
        chk("reach_isb_round5", 32'(found), 32'd1);
        load = 1'b1;
        cyc();
        chk("abort_out", 32'({done1, op1, round1, inv1}), 32'({1'b0, 4'd1, 4'd0, 1'b0}));
        load = 1'b0;
        cyc();
        chk("abort_restart_fwd", 32'(fwd1), 32'd1);
        lat1 = -1;
        lat2 = -1;
        for (int c = 1; c <= 130; c++) begin
            cyc();
            if (done1 && lat1 < 0) lat1 = c;
            if (done2 && lat2 < 0) lat2 = c;
        end
        chk("abort_latency_sw1", 32'(lat1), 32'd50);
        chk("abort_latency_sw2", 32'(lat2), 32'd60);

        // Reset mid key expansion.
        load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (fwd1 && round1 == 4'd4) found = 1'b1;
            else cyc();
        end
        chk("reach_keyexp_round4", 32'(found), 32'd1);
        reset = 1'b1;
        cyc();
        chk("reset_mid_sw1", 32'({done1, op1, round1, fwd1, inv1}), 32'd0);
        chk("reset_mid_sw2", 32'({done2, op2, round2, fwd2, inv2}), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) cyc();
        chk("idle_after_reset", 32'({done1, op1, round1, fwd1, inv1}), 32'd0);

        // Randomised load pulses and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            load  = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 999) == 0);
            cyc();
        end
        load  = 1'b0;
        reset = 1'b0;
        cyc();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
